// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants and bus types.
package inst_fetch_pkg;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] NopInst   = 32'h0000_0000;

  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;

  typedef struct packed {
    InstAddrBus pc;
    InstBus     inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO used for the fetch buffer and the pending-pc queue.
// Push while full is accepted only together with a pop; clear wins over push.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: credit-limited imem requests, response buffer, registered decode output.
// Optional INST_FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect error (fetch_err_o).
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
`ifdef INST_FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_err_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  InstAddrBus   pc_q, pc_d;
  InstAddrBus   id_pc_q, id_pc_d;
  InstBus       id_inst_q, id_inst_d;
  logic         id_valid_q, id_valid_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] buf_cnt, pend_cnt;
  logic [CW:0]   credit_used;
  logic          fetch_blocked;
  InstAddrBus    new_pc_eff;
  InstAddrBus    pend_pc;
  fetch_entry_t  buf_head, buf_wdata;
  logic          handshake, keep_rsp, buf_pop;

`ifdef INST_FETCH_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable)  err_q <= 1'b0;
    else if (flush_i)      err_q <= (new_pc_i[1:0] != 2'b00);
  end

  assign fetch_blocked = err_q;
  assign fetch_err_o   = err_q;
  assign new_pc_eff    = new_pc_i;
`else
  assign fetch_blocked = 1'b0;
  assign new_pc_eff    = new_pc_i & ~32'h3;
`endif

  // Buffered plus in-flight words never exceed the buffer depth, so responses always fit.
  assign credit_used = {1'b0, buf_cnt} + {1'b0, pend_cnt};
  assign imem_req_o  = (rst != RstEnable) && !flush_i && !fetch_blocked &&
                       (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;
  assign handshake   = imem_req_o && imem_gnt_i;

  assign keep_rsp  = imem_rvalid_i && (discard_q == '0) && !flush_i;
  assign buf_pop   = !flush_i && !stall_i && (buf_cnt != '0);
  assign buf_wdata = '{pc: pend_pc, inst: imem_rdata_i};

  // Pending queue is never cleared: responses already in flight still arrive and must pop it.
  fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pend_q (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .push_i  (handshake),
    .wdata_i (pc_q),
    .pop_i   (imem_rvalid_i),
    .rdata_o (pend_pc),
    .count_o (pend_cnt)
  );

  fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush_i),
    .push_i  (keep_rsp),
    .wdata_i (buf_wdata),
    .pop_i   (buf_pop),
    .rdata_o (buf_head),
    .count_o (buf_cnt)
  );

  always_comb begin
    pc_d = pc_q;
    if (flush_i)        pc_d = new_pc_eff;
    else if (handshake) pc_d = pc_q + 32'd4;
  end

  always_comb begin
    discard_d = discard_q;
    if (flush_i)                                 discard_d = pend_cnt - CW'(imem_rvalid_i);
    else if (imem_rvalid_i && discard_q != '0)   discard_d = discard_q - CW'(1);
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (flush_i) begin
      id_inst_d  = NopInst;
      id_valid_d = 1'b0;
    end else if (!stall_i) begin
      if (buf_cnt != '0) begin
        id_pc_d    = buf_head.pc;
        id_inst_d  = buf_head.inst;
        id_valid_d = 1'b1;
      end else begin
        id_inst_d  = NopInst;
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q       <= RESET_PC;
      discard_q  <= '0;
      id_pc_q    <= ZeroWord;
      id_inst_q  <= NopInst;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;

endmodule
